// File: rtl/spi_fpu_framer_pkg.sv
// Shared definitions for the SPI-to-FPU command framer: state encoding,
// opcode byte layout, response length and the FPU operation codes.
package spi_fpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPERAND = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESP    = 3'd4,
    ST_SKIP    = 3'd5,
    ST_DRAIN   = 3'd6
  } state_t;

  localparam int         OP_MSB     = 3;
  localparam int         UNARY_BIT  = 4;
  localparam logic [7:0] RSVD_MASK  = 8'hE0;
  localparam int         RESP_BYTES = 5;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_SQRT = 4'h3;
  localparam logic [3:0] OP_DIV  = 4'h4;

  function automatic logic rsvd_ok(input logic [7:0] op_byte);
    return (op_byte & RSVD_MASK) == 8'h00;
  endfunction

endpackage

// File: rtl/spi_fpu_framer_serializer.sv
// Holds one FPU response (status byte plus result word) and emits it
// MSB-first over a valid/ready byte handshake; flush drops the remainder.
module fpu_word_serializer
  import spi_fpu_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32,
  parameter int FLAG_WIDTH    = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     flush,
  input  logic [OPERAND_WIDTH-1:0] result,
  input  logic [FLAG_WIDTH-1:0]    flags,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_last
);

  localparam int NB = OPERAND_WIDTH / 8 + 1;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  logic [8*NB-1:0] shift_r;
  logic [IW-1:0]   idx_r;
  logic            valid_r;

  // Response shift register; the head byte is always the one on offer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_r <= '0;
      idx_r   <= '0;
      valid_r <= 1'b0;
    end else if (flush) begin
      idx_r   <= '0;
      valid_r <= 1'b0;
    end else if (load) begin
      shift_r <= {8'(flags), result};
      idx_r   <= '0;
      valid_r <= 1'b1;
    end else if (valid_r && out_ready) begin
      if (idx_r == LAST_IDX) begin
        valid_r <= 1'b0;
      end else begin
        shift_r <= shift_r << 4'd8;
        idx_r   <= idx_r + 1'b1;
      end
    end
  end

  assign out_valid = valid_r;
  assign out_data  = shift_r[8*NB-1 -: 8];
  assign out_last  = (idx_r == LAST_IDX);

endmodule

// File: rtl/spi_fpu_framer.sv
// Frames SPI bytes into one FPU request (opcode, A, optional B) and returns
// the status/result bytes; chip-select release aborts a partial frame.
module spi_fpu_framer
  import spi_fpu_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32,
  parameter int FLAG_WIDTH    = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_data_valid,
  input  logic [7:0]               in_data,
  input  logic                     active,
  output logic                     out_data_valid,
  output logic [7:0]               out_data,
  input  logic                     out_data_ready,
  output logic                     fpu_valid,
  input  logic                     fpu_ready,
  output logic [3:0]               fpu_opcode,
  output logic [OPERAND_WIDTH-1:0] fpu_a,
  output logic [OPERAND_WIDTH-1:0] fpu_b,
  input  logic                     fpu_result_valid,
  input  logic [OPERAND_WIDTH-1:0] fpu_result,
  input  logic [FLAG_WIDTH-1:0]    fpu_flags,
  output logic                     busy,
  output logic                     frame_error
);

  localparam int NBW = OPERAND_WIDTH / 8;
  localparam int CW  = $clog2(2 * NBW);
  localparam logic [CW-1:0] LAST_A = CW'(NBW - 1);
  localparam logic [CW-1:0] LAST_B = CW'(2 * NBW - 1);

  state_t                   state_r;
  logic [CW-1:0]            cnt_r;
  logic [3:0]               opcode_r;
  logic                     unary_r;
  logic [OPERAND_WIDTH-1:0] a_r;
  logic [OPERAND_WIDTH-1:0] b_r;
  logic                     fpu_valid_r;
  logic                     busy_r;
  logic                     frame_error_r;
  logic                     active_d_r;
  logic                     fall_s;
  logic                     load_s;
  logic                     flush_s;
  logic                     ser_valid_s;
  logic                     ser_last_s;

  assign fall_s = active_d_r & ~active;

  // Serializer control: load on the result pulse, flush on abort mid-response.
  always_comb begin
    load_s  = 1'b0;
    flush_s = 1'b0;
    if (state_r == ST_WAIT) begin
      load_s = fpu_result_valid && !fall_s;
    end else if (state_r == ST_RESP) begin
      flush_s = fall_s;
    end else begin
      load_s  = 1'b0;
      flush_s = 1'b0;
    end
  end

  // Frame state machine with registered request, busy and error outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      opcode_r      <= 4'h0;
      unary_r       <= 1'b0;
      a_r           <= '0;
      b_r           <= '0;
      fpu_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      frame_error_r <= 1'b0;
      active_d_r    <= 1'b0;
    end else begin
      active_d_r    <= active;
      frame_error_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_data_valid && !fall_s) begin
            busy_r <= 1'b1;
            if (rsvd_ok(in_data)) begin
              state_r  <= ST_OPERAND;
              opcode_r <= in_data[OP_MSB:0];
              unary_r  <= in_data[UNARY_BIT];
              cnt_r    <= '0;
              a_r      <= '0;
              b_r      <= '0;
            end else begin
              state_r       <= ST_SKIP;
              frame_error_r <= 1'b1;
            end
          end
        end
        ST_OPERAND: begin
          if (fall_s) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            frame_error_r <= 1'b1;
          end else if (in_data_valid) begin
            if (cnt_r <= LAST_A) begin
              a_r <= (a_r << 4'd8) | OPERAND_WIDTH'(in_data);
            end else begin
              b_r <= (b_r << 4'd8) | OPERAND_WIDTH'(in_data);
            end
            if ((unary_r && cnt_r == LAST_A) || cnt_r == LAST_B) begin
              state_r     <= ST_ISSUE;
              fpu_valid_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (fall_s) begin
            fpu_valid_r <= 1'b0;
            if (fpu_ready) begin
              state_r <= ST_DRAIN;
            end else begin
              state_r       <= ST_IDLE;
              busy_r        <= 1'b0;
              frame_error_r <= 1'b1;
            end
          end else if (fpu_ready) begin
            state_r     <= ST_WAIT;
            fpu_valid_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          // A result coinciding with the abort is simply discarded.
          if (fall_s) begin
            if (fpu_result_valid) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_DRAIN;
            end
          end else if (fpu_result_valid) begin
            state_r <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (fall_s || (ser_valid_s && out_data_ready && ser_last_s)) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_SKIP: begin
          if (!active) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (fpu_result_valid) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          fpu_valid_r <= 1'b0;
        end
      endcase
    end
  end

  fpu_word_serializer #(
    .OPERAND_WIDTH(OPERAND_WIDTH),
    .FLAG_WIDTH   (FLAG_WIDTH)
  ) u_serializer (
    .clock    (clock),
    .reset    (reset),
    .load     (load_s),
    .flush    (flush_s),
    .result   (fpu_result),
    .flags    (fpu_flags),
    .out_ready(out_data_ready),
    .out_valid(ser_valid_s),
    .out_data (out_data),
    .out_last (ser_last_s)
  );

  assign out_data_valid = ser_valid_s;
  assign fpu_valid      = fpu_valid_r;
  assign fpu_opcode     = opcode_r;
  assign fpu_a          = a_r;
  assign fpu_b          = b_r;
  assign busy           = busy_r;
  assign frame_error    = frame_error_r;

endmodule
